// File: rtl/regfile_selfcheck_pkg.sv
// Shared types for the run-then-check regfile harness.
// Sequencer state encoding used by regfile_selfcheck.
package regfile_selfcheck_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    CHECK = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/selfcheck_compare.sv
// One-stage compare/accumulate against the expected-value ROM.
// REGFILE_SELFCHECK_MASK_EN adds a per-register compare mask.
module selfcheck_compare
  import regfile_selfcheck_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              issue,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] act,
  input  logic [DATA_W-1:0] exp_data,
`ifdef REGFILE_SELFCHECK_MASK_EN
  input  logic [DATA_W-1:0] exp_mask,
`endif
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_fail_reg,
  output logic [DATA_W-1:0] first_fail_act
);

  logic              vld_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] act_q;
  logic [DATA_W-1:0] diff;
  logic              miss;

`ifdef REGFILE_SELFCHECK_MASK_EN
  assign diff = (act_q ^ exp_data) & exp_mask;
`else
  assign diff = act_q ^ exp_data;
`endif

  // ROM data lags the issued address by one cycle, so compare the held sample
  assign miss = vld_q && (|diff);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q          <= 1'b0;
      idx_q          <= '0;
      act_q          <= '0;
      error_count    <= '0;
      first_fail_reg <= '0;
      first_fail_act <= '0;
    end else begin
      vld_q <= issue;
      if (issue) begin
        idx_q <= idx;
        act_q <= act;
      end
      if (clr) begin
        error_count    <= '0;
        first_fail_reg <= '0;
        first_fail_act <= '0;
      end else if (miss) begin
        error_count <= error_count + 1'b1;
        if (error_count == '0) begin
          first_fail_reg <= idx_q;
          first_fail_act <= act_q;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_selfcheck.sv
// Run-then-check harness: runs the CPU, then sweeps the regfile vs a ROM.
// REGFILE_SELFCHECK_MASK_EN adds the exp_mask input.
module regfile_selfcheck
  import regfile_selfcheck_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int CYC_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic              rwe,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1_cpu,
  output logic [ADDR_W-1:0] rs1_out,
  input  logic [DATA_W-1:0] reg_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
`ifdef REGFILE_SELFCHECK_MASK_EN
  input  logic [DATA_W-1:0] exp_mask,
`endif
  output logic              test_mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_fail_reg,
  output logic [DATA_W-1:0] first_fail_act,
  output logic [CYC_W-1:0]  write_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q;
  logic              armed_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [CYC_W-1:0]  run_len_q;
  logic [ADDR_W-1:0] idx_q;
  logic              start_ok;
  logic              issue;
  logic              run_end;

  // armed_q blocks a start seen on the same edge that reset releases
  assign start_ok = start && armed_q &&
                    (state_q == IDLE || state_q == DONE);
  assign issue    = (state_q == CHECK);
  assign run_end  = (cyc_q == run_len_q - CYC_W'(1));

  assign test_mode = (state_q == CHECK) || (state_q == DRAIN);
  assign busy      = (state_q == RUN) || test_mode;
  assign done      = (state_q == DONE);
  assign pass      = done && (error_count == '0);
  assign rs1_out   = test_mode ? idx_q : rs1_cpu;
  assign exp_addr  = issue ? idx_q : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      cyc_q       <= '0;
      run_len_q   <= '0;
      idx_q       <= '0;
      write_count <= '0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            run_len_q   <= run_cycles;
            cyc_q       <= '0;
            write_count <= '0;
            idx_q       <= '0;
            state_q     <= (run_cycles == '0) ? CHECK : RUN;
          end
        end
        RUN: begin
          cyc_q <= cyc_q + CYC_W'(1);
          if (rwe && rd != '0 && write_count != '1)
            write_count <= write_count + CYC_W'(1);
          if (run_end)
            state_q <= CHECK;
        end
        CHECK: begin
          if (idx_q == LAST_IDX)
            state_q <= DRAIN;
          else
            idx_q <= idx_q + ADDR_W'(1);
        end
        DRAIN: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  selfcheck_compare #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .clock          (clock),
    .reset_n        (reset_n),
    .clr            (start_ok),
    .issue          (issue),
    .idx            (idx_q),
    .act            (reg_data),
    .exp_data       (exp_data),
`ifdef REGFILE_SELFCHECK_MASK_EN
    .exp_mask       (exp_mask),
`endif
    .error_count    (error_count),
    .first_fail_reg (first_fail_reg),
    .first_fail_act (first_fail_act)
  );

endmodule

// File: tb/tb_regfile_selfcheck.sv
// Directed bench for regfile_selfcheck with regfile and ROM models.
// Mask cases build only with REGFILE_SELFCHECK_MASK_EN.
module tb_regfile_selfcheck;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] run_cycles;
  logic        rwe;
  logic [4:0]  rd;
  logic [4:0]  rs1_cpu;
  logic [4:0]  rs1_out;
  logic [31:0] reg_data;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        test_mode;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  error_count;
  logic [4:0]  first_fail_reg;
  logic [31:0] first_fail_act;
  logic [15:0] write_count;

  logic        start_s;
  logic [3:0]  run_cycles_s;
  logic [4:0]  rs1_out_s;
  logic [31:0] reg_data_s;
  logic [4:0]  exp_addr_s;
  logic [31:0] exp_data_s;
  logic        test_mode_s;
  logic        busy_s;
  logic        done_s;
  logic        pass_s;
  logic [5:0]  error_count_s;
  logic [4:0]  first_fail_reg_s;
  logic [31:0] first_fail_act_s;
  logic [3:0]  write_count_s;

  logic [31:0] regs [32];
  logic [31:0] rom  [32];
`ifdef REGFILE_SELFCHECK_MASK_EN
  logic [31:0] mask [32];
  logic [31:0] exp_mask;
  logic [31:0] exp_mask_s;
  always @(posedge clock) begin
    exp_mask   <= mask[exp_addr];
    exp_mask_s <= mask[exp_addr_s];
  end
`endif

  int checks = 0;
  int errors = 0;
  int n;

  assign reg_data   = regs[rs1_out];
  assign reg_data_s = regs[rs1_out_s];

  always @(posedge clock) begin
    exp_data   <= rom[exp_addr];
    exp_data_s <= rom[exp_addr_s];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  regfile_selfcheck dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .run_cycles     (run_cycles),
    .rwe            (rwe),
    .rd             (rd),
    .rs1_cpu        (rs1_cpu),
    .rs1_out        (rs1_out),
    .reg_data       (reg_data),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
`ifdef REGFILE_SELFCHECK_MASK_EN
    .exp_mask       (exp_mask),
`endif
    .test_mode      (test_mode),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error_count    (error_count),
    .first_fail_reg (first_fail_reg),
    .first_fail_act (first_fail_act),
    .write_count    (write_count)
  );

  regfile_selfcheck #(.CYC_W(4)) dut_s (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start_s),
    .run_cycles     (run_cycles_s),
    .rwe            (rwe),
    .rd             (rd),
    .rs1_cpu        (rs1_cpu),
    .rs1_out        (rs1_out_s),
    .reg_data       (reg_data_s),
    .exp_addr       (exp_addr_s),
    .exp_data       (exp_data_s),
`ifdef REGFILE_SELFCHECK_MASK_EN
    .exp_mask       (exp_mask_s),
`endif
    .test_mode      (test_mode_s),
    .busy           (busy_s),
    .done           (done_s),
    .pass           (pass_s),
    .error_count    (error_count_s),
    .first_fail_reg (first_fail_reg_s),
    .first_fail_act (first_fail_act_s),
    .write_count    (write_count_s)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start edge counts as edge 1; returns edges until done is seen
  task automatic kick(input logic [15:0] rc, input bit hold);
    run_cycles = rc;
    start = 1'b1;
    step();
    n = 1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (!done && n < 400) begin
      step();
      n++;
    end
    start = 1'b0;
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    start_s      = 1'b0;
    run_cycles   = '0;
    run_cycles_s = '0;
    rwe          = 1'b0;
    rd           = '0;
    rs1_cpu      = 5'd9;
    for (int i = 0; i < 32; i++) begin
      regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + i * 32'h0101;
      rom[i]  = regs[i];
`ifdef REGFILE_SELFCHECK_MASK_EN
      mask[i] = 32'hFFFF_FFFF;
`endif
    end

    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_tmode", 64'(test_mode), 64'd0);
    chk("rst_errs", 64'(error_count), 64'd0);
    chk("rst_wcnt", 64'(write_count), 64'd0);
    chk("rst_eaddr", 64'(exp_addr), 64'd0);
    chk("rst_rs1", 64'(rs1_out), 64'd9);

    // start pulse coincident with reset release must be ignored
    start = 1'b1;
    reset_n = 1'b1;
    step();
    start = 1'b0;
    chk("rel_start", 64'(busy), 64'd0);

    // reset in RUN at cycle 5
    kick(16'd10, 1'b0);
    chk("run_busy", 64'(busy), 64'd1);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_tmode", 64'(test_mode), 64'd0);
    chk("mid_rs1", 64'(rs1_out), 64'd9);
    step();
    reset_n = 1'b1;
    step();

    kick(16'd10, 1'b0);
    wait_done("lat10_done");
    chk("lat10_n", 64'(n), 64'd44);
    chk("lat10_pass", 64'(pass), 64'd1);
    chk("lat10_errs", 64'(error_count), 64'd0);

    // writes rd=3,0,7,0,9 in RUN, then a write during CHECK
    kick(16'd20, 1'b0);
    rwe = 1'b1;
    rd = 5'd3; step();
    rd = 5'd0; step();
    rd = 5'd7; step();
    rd = 5'd0; step();
    rd = 5'd9; step();
    rwe = 1'b0;
    n = 6;
    while (!test_mode && n < 400) begin
      step();
      n++;
    end
    rwe = 1'b1;
    rd = 5'd5;
    wait_done("wr_done");
    rwe = 1'b0;
    chk("wr_cnt", 64'(write_count), 64'd3);
    chk("wr_pass", 64'(pass), 64'd1);
    chk("wr_errs", 64'(error_count), 64'd0);

    regs[4] = 32'd5;
    rom[4] = 32'd6;
    regs[17] = 32'hFFFF_FFFF;
    rom[17] = 32'd0;
    kick(16'd3, 1'b0);
    wait_done("mm_done");
    chk("mm_errs", 64'(error_count), 64'd2);
    chk("mm_freg", 64'(first_fail_reg), 64'd4);
    chk("mm_fact", 64'(first_fail_act), 64'd5);
    chk("mm_pass", 64'(pass), 64'd0);

    // restart from DONE with zero run length and a matching ROM
    rom[4] = 32'd5;
    rom[17] = 32'hFFFF_FFFF;
    rwe = 1'b1;
    rd = 5'd3;
    kick(16'd0, 1'b0);
    chk("z_tmode", 64'(test_mode), 64'd1);
    chk("z_rs1", 64'(rs1_out), 64'd0);
    chk("z_errclr", 64'(error_count), 64'd0);
    step();
    n++;
    chk("z_sweep1", 64'(rs1_out), 64'd1);
    chk("z_eaddr1", 64'(exp_addr), 64'd1);
    wait_done("z_done");
    rwe = 1'b0;
    chk("z_n", 64'(n), 64'd34);
    chk("z_wcnt", 64'(write_count), 64'd0);
    chk("z_pass", 64'(pass), 64'd1);

    // start held high through RUN and CHECK
    kick(16'd5, 1'b1);
    wait_done("hold_done");
    chk("hold_n", 64'(n), 64'd39);
    step();
    chk("hold_stay", 64'(done), 64'd1);

    // 4-bit counter instance fed a write every cycle
    rwe = 1'b1;
    rd = 5'd1;
    run_cycles_s = 4'd15;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    n = 1;
    while (!done_s && n < 400) begin
      step();
      n++;
    end
    rwe = 1'b0;
    chk("sat_done", 64'(done_s), 64'd1);
    chk("sat_wcnt", 64'(write_count_s), 64'd15);
    chk("sat_pass", 64'(pass_s), 64'd1);

`ifdef REGFILE_SELFCHECK_MASK_EN
    regs[2] = 32'h0000_00FF;
    rom[2] = 32'h0000_0000;
    mask[2] = 32'hFFFF_FF00;
    kick(16'd0, 1'b0);
    wait_done("mk_done");
    chk("mk_errs", 64'(error_count), 64'd0);
    chk("mk_pass", 64'(pass), 64'd1);
    mask[2] = 32'hFFFF_FFFF;
    kick(16'd0, 1'b0);
    wait_done("mk2_done");
    chk("mk2_errs", 64'(error_count), 64'd1);
    chk("mk2_freg", 64'(first_fail_reg), 64'd2);
    chk("mk2_fact", 64'(first_fail_act), 64'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_selfcheck.md
Name: regfile_selfcheck

Overview:
- Synthesizable run-then-check harness that sits between the processor and the register file, and lets a board or wrapper self-test a program without a simulator.
- Counts a programmable number of processor cycles and logs register writes during that run.
- Then takes over the regfile read-port-A address and sweeps NUM_REGS registers against an expected-value ROM.
- Reports pass/fail, the error count and the first mismatch.

Parameters:
- NUM_REGS, 32, number of registers swept (r0..NUM_REGS-1).
- ADDR_W, 5, register address width; NUM_REGS <= 2**ADDR_W.
- DATA_W, 32, register and expected-value width.
- CYC_W, 16, width of the run-cycle count and write counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins RUN; ignored unless state is IDLE or DONE.
- run_cycles  in  CYC_W  cycles to run before checking; sampled on accepted start.
- rwe  in  1  processor regfile write enable (monitored).
- rd  in  ADDR_W  processor write register (monitored).
- rs1_cpu  in  ADDR_W  processor read-A address.
- rs1_out  out  ADDR_W  regfile read-A address: rs1_cpu when test_mode=0, else sweep index.
- reg_data  in  DATA_W  regfile read-A data (combinational read).
- exp_addr  out  ADDR_W  expected-ROM address.
- exp_data  in  DATA_W  expected-ROM data; synchronous, 1-cycle latency.
- test_mode  out  1  high in CHECK and DRAIN.
- busy  out  1  high in RUN, CHECK and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid in DONE; 1 iff error_count==0.
- error_count  out  ADDR_W+1  mismatching registers.
- first_fail_reg  out  ADDR_W  index of first mismatch.
- first_fail_act  out  DATA_W  actual value of first mismatch.
- write_count  out  CYC_W  qualifying writes during RUN; saturates at all-ones.

Behaviour:
- Reset: state IDLE; test_mode, busy, done, pass = 0; all counters and captured fields = 0; exp_addr = 0.
- States:
  - IDLE: waits for start.
  - RUN: on entry, cycle counter and write_count clear. Each cycle, cycle counter increments and write_count increments if rwe && rd!=0. Moves to CHECK when cycle counter == run_cycles-1. run_cycles==0 goes IDLE->CHECK directly, with write_count=0.
  - CHECK: index i runs 0..NUM_REGS-1, one per cycle. rs1_out=exp_addr=i. reg_data is registered into act_q together with idx_q=i and vld_q=1. After i=NUM_REGS-1 -> DRAIN.
  - DRAIN: one cycle; final compare completes; -> DONE.
  - DONE: holds results; start restarts in RUN and clears error_count, first_fail_* and write_count.
- Compare pipeline: the cycle after issue, if vld_q and act_q != exp_data, error_count increments. If that was the first mismatch, first_fail_reg=idx_q and first_fail_act=act_q.
- Latency: start to done = run_cycles + NUM_REGS + 1 cycles (+1 for DONE entry); total RUN cycles = run_cycles.
- rs1_out switches combinationally on test_mode; no glitch requirement.
- Monitoring: rwe during CHECK/DRAIN is not counted. rd==0 writes are never counted.
- Reset mid-operation (any state): immediate return to reset values; test_mode drops asynchronously.
- start while busy is ignored. start and reset_n release in the same cycle: start is ignored.

Optional Feature:
- Macro: REGFILE_SELFCHECK_MASK_EN.
- Defined: adds input exp_mask [DATA_W], aligned with exp_data (same 1-cycle latency). Mismatch is ((act_q ^ exp_data) & exp_mask) != 0. A mask of 0 makes the register don't-care.
- Undefined: port absent; full-width compare.

Decomposition:
- Shared package regfile_selfcheck_pkg: state enum (IDLE, RUN, CHECK, DRAIN, DONE), state encoding width.
- One sub-module: selfcheck_compare, the 1-stage compare/accumulate holding act_q, idx_q, vld_q, error_count and first_fail_*.
- Sequencer FSM and counters stay in the top.

Test Plan:
- Reset during RUN at cycle 5 -> all outputs 0, test_mode=0, rs1_out follows rs1_cpu. After release, start with run_cycles=10 -> done exactly 10+32+2 cycles after start.
- run_cycles=20; write pulses with rd=3,0,7,0,9 -> write_count=3. ROM matches regfile -> pass=1, error_count=0.
- Regfile r4=5, r17=-1 vs ROM r4=6, r17=0 -> error_count=2, first_fail_reg=4, first_fail_act=5, pass=0.
- run_cycles=0 -> CHECK entered on the cycle after start; write_count=0; sweep completes normally.
- start held high throughout RUN/CHECK -> no restart. start in DONE -> new run, error_count cleared. CYC_W=4, 20 writes -> write_count=15.
- MASK_EN: r2 act=0x0000_00FF, exp=0x0000_0000, mask=0xFFFF_FF00 -> no error. With mask=0xFFFF_FFFF -> error_count=1.
